mul_seq_ctrl: RTL and testbench
===============================

Name: mul_seq_ctrl

Overview:
- Multi-cycle sequencer for the M-extension multiply ops decoded into ALUop 4'b1100 to 4'b1111 (MUL, MULH, MULHSU, MULHU).
- Sits beside the EX-stage ALU. It accepts one multiply, holds the pipeline via stall while it iterates a shift-add datapath, then returns the selected 32-bit result for one cycle.
- It replaces a single-cycle 32x32 array multiplier on the critical path.

Parameters:
- XLEN, 32, operand/result width.
- BITS_PER_CYCLE, 1, multiplier bits consumed per CALC cycle. Legal values are 1, 2, 4, and the value must divide XLEN.
- N (local, not overridable) = XLEN/BITS_PER_CYCLE, the iteration count.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  EX stage holds a valid multiply (ALUop[3:2]==2'b11). Sampled only in IDLE.
- op  input  2  ALUop[1:0]: 00 MUL (low word), 01 MULH (signed x signed, high), 10 MULHSU (signed src1 x unsigned src2, high), 11 MULHU (unsigned x unsigned, high).
- src1  input  XLEN  rs1 operand after forwarding.
- src2  input  XLEN  rs2 operand after forwarding.
- flush  input  1  abort the in-flight multiply (trap/interrupt redirect).
- stall  output  1  freeze IF/ID/EX; combinational.
- done  output  1  one-cycle pulse; result valid this cycle.
- result  output  XLEN  registered product word; holds until next done.

Behaviour:
- States are IDLE, CALC, FIX, DONE. Reset (async, rst=1) forces state=IDLE, cnt=0, result=0, done=0, and all internal accumulators=0. With start=0, stall=0.
- IDLE:
  - If start=1 and flush=0: latch op. Latch the magnitudes |src1| and |src2|, each taken only if that operand is signed for op. Latch neg = sign1 XOR sign2 for signed operands. Set cnt=N, clear the 2*XLEN accumulator, go to CALC.
  - MUL treats both operands as unsigned, because the low word is sign-independent.
  - Magnitude of 0x80000000 is 0x80000000 (unsigned, no overflow).
- CALC:
  - Each cycle, add the multiplicand times the low BITS_PER_CYCLE multiplier bits into the accumulator, then shift.
  - cnt decrements each cycle. When cnt reaches 0, go to FIX.
  - Latency is fixed: there is no early termination on zero operands.
- FIX: apply two's-complement negation of the 64-bit product if neg=1. Select low word (MUL) or high word (others) into result. Go to DONE.
- DONE: done=1 for exactly this cycle. Go to IDLE next edge. start is ignored in DONE because it still reflects the retiring instruction.
- Timing: with start accepted in cycle c, done=1 in cycle c+N+2 (c+34 for defaults).
- stall:
  - stall = (state==IDLE and start and not flush) or state==CALC or state==FIX.
  - stall is high for cycles c through c+N+1 and low in the DONE cycle, so the pipeline advances and captures result.
- Back-to-back: a new start seen in the IDLE cycle right after DONE is accepted normally. There is a one-cycle gap between consecutive multiplies.
- flush:
  - flush has priority over start and over all states. stall is forced 0 in the flush cycle, state goes to IDLE next edge, and done is not asserted for the aborted op.
  - result keeps its prior value.
  - flush in the DONE cycle: done still pulses that cycle (result already committed), then IDLE.
- Reset mid-operation: immediate return to the reset values above. No done is produced.
- Operand stability: src1, src2 and op are used only at acceptance. Later changes are ignored.

Test Plan:
- MUL, src1=7, src2=6, start at cycle c -> stall=1 for c..c+33, done=1 only at c+34, result=0x0000002A.
- MULH, 0x80000000 x 0x80000000 -> result=0x40000000. MULH, 0xFFFFFFFF x 0x00000001 -> result=0xFFFFFFFF.
- MULHSU, 0xFFFFFFFF x 0xFFFFFFFF -> result=0xFFFFFFFF. MULHU with the same operands -> result=0xFFFFFFFE.
- flush asserted at c+10 -> stall=0 that cycle, no done, state IDLE at c+11, result unchanged. A new MUL 3x5 started at c+12 -> done at c+46, result=0x0000000F.
- rst pulsed asynchronously mid-CALC -> stall, done, result go to 0 immediately. Then MULHU 0x00010000 x 0x00010000 -> result=0x00000001.
- Back-to-back MUL 2x3 then MUL 4x5 -> done pulses at c+34 (0x6) and c+35+34 (0x14). start held through DONE is not re-accepted.

Source files
------------

// File: rtl/mul_seq_ctrl.sv
// Iterative shift-add multiplier sequencer for MUL/MULH/MULHSU/MULHU.
// Holds the pipeline via stall while iterating, then pulses done with the selected word.
module mul_seq_ctrl #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            flush,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int B  = BITS_PER_CYCLE;
  localparam int N  = XLEN / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e              state;
  logic [CW-1:0]       cnt;
  logic [1:0]          op_q;
  logic                neg;
  logic [XLEN-1:0]     mcand;
  logic [XLEN-1:0]     mplier;
  logic [2*XLEN-1:0]   acc;

  logic                sign1;
  logic                sign2;
  logic [XLEN-1:0]     mag1;
  logic [XLEN-1:0]     mag2;
  logic [XLEN+B-1:0]   partial;
  logic [XLEN+B-1:0]   sum;
  logic [2*XLEN-1:0]   acc_next;
  logic [2*XLEN-1:0]   prod;

  always_comb begin
    // MUL low word is sign-independent, so only MULH/MULHSU treat src1 as signed
    sign1    = (op == 2'b01 || op == 2'b10) && src1[XLEN-1];
    sign2    = (op == 2'b01) && src2[XLEN-1];
    mag1     = sign1 ? -src1 : src1;
    mag2     = sign2 ? -src2 : src2;
    partial  = {{B{1'b0}}, mcand} * {{XLEN{1'b0}}, mplier[B-1:0]};
    sum      = {{B{1'b0}}, acc[2*XLEN-1:XLEN]} + partial;
    // Product grows in the upper half and shifts right as multiplier bits retire
    acc_next = {sum, acc[XLEN-1:B]};
    prod     = neg ? -acc : acc;
  end

  assign stall = !flush && ((state == StIdle && start) || state == StCalc || state == StFix);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= StIdle;
      cnt    <= '0;
      op_q   <= '0;
      neg    <= 1'b0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      result <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start && !flush) begin
            op_q   <= op;
            mcand  <= mag1;
            mplier <= mag2;
            neg    <= sign1 ^ sign2;
            cnt    <= CW'(N);
            acc    <= '0;
            state  <= StCalc;
          end
        end
        StCalc: begin
          if (flush) begin
            state <= StIdle;
          end else begin
            acc    <= acc_next;
            mplier <= mplier >> B;
            cnt    <= cnt - CW'(1);
            if (cnt == CW'(1)) state <= StFix;
          end
        end
        StFix: begin
          if (flush) begin
            state <= StIdle;
          end else begin
            result <= (op_q == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
            done   <= 1'b1;
            state  <= StDone;
          end
        end
        StDone: state <= StIdle;
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Randomized, self-checking bench for mul_seq_ctrl against a cycle-level behavioural model.
module tb_mul_seq_ctrl;

  localparam int N = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] src1 = '0;
  logic [31:0] src2 = '0;
  logic        flush = 1'b0;
  logic        stall;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  // Model: phase 0 = idle, k = k-th cycle after acceptance (N+2 is the done cycle)
  int          phase = 0;
  logic [31:0] pend = '0;
  logic [31:0] exp_result = '0;

  mul_seq_ctrl dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .src1  (src1),
    .src2  (src2),
    .flush (flush),
    .stall (stall),
    .done  (done),
    .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_mul(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
    longint x;
    longint y;
    logic [63:0] p;
    x = (o == 2'b01 || o == 2'b10) ? longint'($signed(a)) : longint'({32'h0, a});
    y = (o == 2'b01) ? longint'($signed(b)) : longint'({32'h0, b});
    p = 64'(x * y);
    return (o == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  always @(negedge clk) begin
    logic e_stall;
    logic e_done;
    if (rst) begin
      phase      = 0;
      exp_result = '0;
    end
    e_stall = !flush && ((phase == 0 && start) || (phase >= 1 && phase <= N + 1));
    e_done  = (phase == N + 2);
    check("cyc_stall", 64'(stall), 64'(e_stall));
    check("cyc_done", 64'(done), 64'(e_done));
    check("cyc_result", 64'(result), 64'(exp_result));
    if (!rst) begin
      if (phase == 0) begin
        if (start && !flush) begin
          phase = 1;
          pend  = ref_mul(op, src1, src2);
        end
      end else if (phase <= N + 1) begin
        if (flush) phase = 0;
        else begin
          phase++;
          if (phase == N + 2) exp_result = pend;
        end
      end else begin
        phase = 0;
      end
    end
  end

  // Issue one op in the current cycle (called at posedge+1); returns one cycle after done
  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    int lat;
    int nstall;
    logic [31:0] res;
    lat    = -1;
    nstall = 0;
    res    = '0;
    start  = 1'b1;
    op     = o;
    src1   = a;
    src2   = b;
    for (int k = 0; k <= 40; k++) begin
      #3;
      if (stall) nstall++;
      if (done) begin
        lat = k;
        res = result;
      end
      @(posedge clk);
      #1;
      if (k == 0) begin
        start = 1'b0;
        op    = 2'($urandom);
        src1  = $urandom;
        src2  = $urandom;
      end
      if (lat >= 0) break;
    end
    check({name, "_latency"}, 64'(lat), 64'(N + 2));
    check({name, "_stall_cycles"}, 64'(nstall), 64'(N + 2));
    check({name, "_result"}, 64'(res), 64'(exp));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #3;
    check("reset_stall", 64'(stall), 64'(0));
    check("reset_done", 64'(done), 64'(0));
    check("reset_result", 64'(result), 64'(0));
    @(posedge clk);
    #1;

    run_op("mul_7x6", 2'b00, 32'd7, 32'd6, 32'h0000_002A);
    run_op("mulh_min", 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    run_op("mulh_m1", 2'b01, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF);
    run_op("mulhsu", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mulhu", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);

    // Flush at c+10 aborts the op; result must keep the previous value
    start = 1'b1;
    op    = 2'b00;
    src1  = 32'd9;
    src2  = 32'd9;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) start = 1'b0;
    end
    flush = 1'b1;
    #3;
    check("flush_stall", 64'(stall), 64'(0));
    check("flush_done", 64'(done), 64'(0));
    @(posedge clk);
    #1;
    flush = 1'b0;
    #3;
    check("post_flush_stall", 64'(stall), 64'(0));
    check("post_flush_result", 64'(result), 64'(32'hFFFF_FFFE));
    @(posedge clk);
    #1;
    run_op("mul_3x5", 2'b00, 32'd3, 32'd5, 32'h0000_000F);

    // Asynchronous reset mid-CALC
    start = 1'b1;
    op    = 2'b01;
    src1  = 32'd5;
    src2  = 32'd5;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) start = 1'b0;
    end
    #2;
    rst = 1'b1;
    #1;
    check("arst_stall", 64'(stall), 64'(0));
    check("arst_done", 64'(done), 64'(0));
    check("arst_result", 64'(result), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_op("mulhu_2p16", 2'b11, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001);

    run_op("b2b_first", 2'b00, 32'd2, 32'd3, 32'h0000_0006);
    run_op("b2b_second", 2'b00, 32'd4, 32'd5, 32'h0000_0014);

    // Random traffic; start often held through DONE, occasional flushes
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      #1;
      start = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 149) == 0);
      op    = 2'($urandom);
      src1  = pick();
      src2  = pick();
    end
    start = 1'b0;
    flush = 1'b0;
    repeat (40) @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
